// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered long-latency results
// onto the register file write port, with a starvation guard and busy scoreboard.
module writeback_arbiter #(
   parameter int DATA_W       = 48,
   parameter int ADDR_W       = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [ADDR_W-1:0]             alu_rd,
   input  logic [DATA_W-1:0]             alu_data,
   input  logic                          mem_valid,
   output logic                          mem_ready,
   input  logic [ADDR_W-1:0]             mem_rd,
   input  logic [DATA_W-1:0]             mem_data,
   input  logic                          issue_valid,
   input  logic [ADDR_W-1:0]             issue_rd,
   input  logic [ADDR_W-1:0]             q_rs1,
   input  logic [ADDR_W-1:0]             q_rs2,
   output logic                          rs1_busy,
   output logic                          rs2_busy,
   output logic [ADDR_W-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          reg_write,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;
   localparam int SW   = $clog2(STARVE_LIMIT) + 1;
   localparam int NREG = 1 << ADDR_W;
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_PRE = SW'(STARVE_LIMIT - 2);

   logic [ADDR_W-1:0] r_fifo_rd   [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [SW-1:0]     r_starve_cnt;
   logic              r_alu_ready;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_reg_write;
   logic              r_wb_from_mem;
   logic [NREG-1:0]   r_busy;

   logic              w_fifo_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_alu_take;
   logic              w_starve_hit;
   logic [ADDR_W-1:0] w_head_rd;
   logic [DATA_W-1:0] w_head_data;

   assign w_fifo_empty = (r_count == '0);
   assign mem_ready    = reset_n && (r_count < DEPTH_C);
   assign w_push       = mem_valid && mem_ready;
   assign w_alu_take   = alu_valid && r_alu_ready;
   assign w_pop        = !w_alu_take && !w_fifo_empty;
   assign w_head_rd    = r_fifo_rd[r_rd_ptr];
   assign w_head_data  = r_fifo_data[r_rd_ptr];
   // Head passed over for the (LIMIT-1)th time: hold the ALU off next cycle.
   assign w_starve_hit = !w_fifo_empty && !w_pop && (r_starve_cnt == STARVE_PRE);

   assign alu_ready  = r_alu_ready;
   assign rd_addr    = r_rd_addr;
   assign rd_data    = r_rd_data;
   assign reg_write  = r_reg_write;
   assign fifo_count = r_count;
   assign rs1_busy   = (q_rs1 != '0) && r_busy[q_rs1];
   assign rs2_busy   = (q_rs2 != '0) && r_busy[q_rs2];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= mem_rd;
         r_fifo_data[r_wr_ptr] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_starve_cnt  <= '0;
         r_alu_ready   <= 1'b1;
         r_rd_addr     <= '0;
         r_rd_data     <= '0;
         r_reg_write   <= 1'b0;
         r_wb_from_mem <= 1'b0;
         r_busy        <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         if (w_pop || w_fifo_empty) r_starve_cnt <= '0;
         else                       r_starve_cnt <= r_starve_cnt + SW'(1);
         r_alu_ready <= !w_starve_hit;

         if (w_alu_take) begin
            r_rd_addr     <= alu_rd;
            r_rd_data     <= alu_data;
            r_reg_write   <= (alu_rd != '0);
            r_wb_from_mem <= 1'b0;
         end else if (w_pop) begin
            r_rd_addr     <= w_head_rd;
            r_rd_data     <= w_head_data;
            r_reg_write   <= (w_head_rd != '0);
            r_wb_from_mem <= 1'b1;
         end else begin
            r_reg_write   <= 1'b0;
            r_wb_from_mem <= 1'b0;
         end

         // Clear coincides with the register file capture; a new issue wins.
         for (int i = 1; i < NREG; i++) begin
            if (issue_valid && (issue_rd == ADDR_W'(i)))
               r_busy[i] <= 1'b1;
            else if (r_reg_write && r_wb_from_mem && (r_rd_addr == ADDR_W'(i)))
               r_busy[i] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_writeback_arbiter;
   localparam int DW = 48, AW = 5, DEPTH = 4, LIMIT = 4;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          mem_valid = 1'b0;
   logic [AW-1:0] mem_rd = '0;
   logic [DW-1:0] mem_data = '0;
   logic          issue_valid = 1'b0;
   logic [AW-1:0] issue_rd = '0;
   logic [AW-1:0] q_rs1 = '0;
   logic [AW-1:0] q_rs2 = '0;
   logic          alu_ready, mem_ready, rs1_busy, rs2_busy, reg_write;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] fifo_count;

   always #5 clk = ~clk;

   writeback_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write), .fifo_count(fifo_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a queue of pending results plus the expected outputs.
   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } res_t;

   res_t          m_q[$];
   logic          m_alu_ready, m_we, m_from_mem;
   logic [AW-1:0] m_rd;
   logic [DW-1:0] m_data;
   logic [31:0]   m_busy;
   int            m_wait;
   logic          m_alu_took, m_mem_took;

   task automatic model_reset();
      m_q.delete();
      m_alu_ready = 1'b1;
      m_we = 1'b0;
      m_from_mem = 1'b0;
      m_rd = '0;
      m_data = '0;
      m_busy = '0;
      m_wait = 0;
      m_alu_took = 1'b0;
      m_mem_took = 1'b0;
   endtask

   task automatic model_check();
      chk("alu_ready", 64'(alu_ready), 64'(m_alu_ready));
      chk("mem_ready", 64'(mem_ready), 64'(m_q.size() < DEPTH));
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("reg_write", 64'(reg_write), 64'(m_we));
      if (m_we) begin
         chk("rd_addr", 64'(rd_addr), 64'(m_rd));
         chk("rd_data", 64'(rd_data), 64'(m_data));
      end
      chk("rs1_busy", 64'(rs1_busy), 64'(q_rs1 != 0 && m_busy[q_rs1]));
      chk("rs2_busy", 64'(rs2_busy), 64'(q_rs2 != 0 && m_busy[q_rs2]));
   endtask

   task automatic model_step();
      int   sz;
      logic pop;
      res_t h;
      sz = m_q.size();
      m_alu_took = alu_valid && m_alu_ready;
      pop = !m_alu_took && (sz > 0);
      if (m_we && m_from_mem) m_busy[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (m_alu_took) begin
         m_rd = alu_rd; m_data = alu_data; m_we = (alu_rd != 0); m_from_mem = 1'b0;
      end else if (pop) begin
         h = m_q.pop_front();
         m_rd = h.rd; m_data = h.data; m_we = (h.rd != 0); m_from_mem = 1'b1;
      end else begin
         m_we = 1'b0; m_from_mem = 1'b0;
      end
      m_mem_took = mem_valid && (sz < DEPTH);
      if (m_mem_took) begin
         h.rd = mem_rd; h.data = mem_data;
         m_q.push_back(h);
      end
      // Count how many cycles the waiting head has been skipped.
      if (sz > 0 && !pop) m_wait++;
      else                m_wait = 0;
      m_alu_ready = (m_wait != LIMIT - 1);
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          alu_valid;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      logic          exp_we;
   } alu_vec_t;

   alu_vec_t vecs[5];

   initial begin
      vecs[0] = '{1'b1, 5'd7,  48'h0000_1234_5678, 1'b1};
      vecs[1] = '{1'b1, 5'd0,  48'h0000_DEAD_BEEF, 1'b0};
      vecs[2] = '{1'b0, 5'd4,  48'h0000_0000_0001, 1'b0};
      vecs[3] = '{1'b1, 5'd31, 48'hFFFF_FFFF_FFFF, 1'b1};
      vecs[4] = '{1'b1, 5'd1,  48'h8000_0000_0001, 1'b1};

      // Reset held with a pending long-latency result.
      mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 48'h55;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_mem_ready", 64'(mem_ready), 64'(0));
      chk("reset_reg_write", 64'(reg_write), 64'(0));
      chk("reset_fifo_count", 64'(fifo_count), 64'(0));
      chk("reset_alu_ready", 64'(alu_ready), 64'(1));
      mem_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      chk("release_mem_ready", 64'(mem_ready), 64'(1));
      @(posedge clk);
      #1;
      model_reset();

      // ALU-only vectors.
      for (int i = 0; i < 5; i++) begin
         alu_valid = vecs[i].alu_valid; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
         cycle();
         chk("vec_reg_write", 64'(reg_write), 64'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            chk("vec_rd_addr", 64'(rd_addr), 64'(vecs[i].rd));
            chk("vec_rd_data", 64'(rd_data), 64'(vecs[i].data));
         end
      end
      alu_valid = 1'b0;

      // Scoreboard: busy clears on the same edge the register file is written.
      q_rs1 = 5'd9; q_rs2 = 5'd0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      cycle();
      issue_valid = 1'b0;
      chk("sb_set", 64'(rs1_busy), 64'(1));
      chk("sb_r0", 64'(rs2_busy), 64'(0));
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 48'h9999_0000_0009;
      cycle();
      mem_valid = 1'b0;
      chk("sb_after_push", 64'(rs1_busy), 64'(1));
      chk("sb_fifo_count", 64'(fifo_count), 64'(1));
      cycle();
      chk("sb_pop_we", 64'(reg_write), 64'(1));
      chk("sb_pop_addr", 64'(rd_addr), 64'(9));
      chk("sb_busy_during_write", 64'(rs1_busy), 64'(1));
      cycle();
      chk("sb_cleared", 64'(rs1_busy), 64'(0));
      chk("sb_we_done", 64'(reg_write), 64'(0));

      // Set and clear of r9 on the same edge: set wins.
      issue_valid = 1'b1; issue_rd = 5'd9;
      cycle();
      issue_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 48'h0000_0000_0909;
      cycle();
      mem_valid = 1'b0;
      cycle();
      issue_valid = 1'b1; issue_rd = 5'd9;
      cycle();
      issue_valid = 1'b0;
      chk("sb_set_wins", 64'(rs1_busy), 64'(1));

      // FIFO fill under continuous ALU traffic, then starvation hold-off.
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 48'h0000_0000_0A1A;
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1; mem_rd = AW'(10 + i); mem_data = DW'(48'hA00 + i);
         cycle();
      end
      chk("full_count", 64'(fifo_count), 64'(4));
      chk("full_mem_ready", 64'(mem_ready), 64'(0));
      chk("starve_alu_ready", 64'(alu_ready), 64'(0));
      mem_rd = 5'd14; mem_data = 48'hA04;
      cycle();
      chk("starve_pop_we", 64'(reg_write), 64'(1));
      chk("starve_pop_data", 64'(rd_data), 64'(48'hA00));
      chk("held_not_pushed", 64'(fifo_count), 64'(3));
      chk("alu_ready_back", 64'(alu_ready), 64'(1));
      cycle();
      mem_valid = 1'b0; alu_valid = 1'b0;
      chk("alu_after_starve_addr", 64'(rd_addr), 64'(3));
      chk("alu_after_starve_data", 64'(rd_data), 64'(48'hA1A));
      chk("fifth_pushed", 64'(fifo_count), 64'(4));
      for (int i = 1; i < 5; i++) begin
         cycle();
         chk("drain_order", 64'(rd_data), 64'(48'hA00 + i));
      end

      // Randomized traffic; sources hold a result until it is accepted.
      for (int n = 0; n < 3000; n++) begin
         if (!(alu_valid && !m_alu_took)) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd = AW'($urandom());
            alu_data = DW'({$urandom(), $urandom()});
         end
         if (!(mem_valid && !m_mem_took)) begin
            mem_valid = ($urandom_range(0, 1) != 0);
            mem_rd = AW'($urandom());
            mem_data = DW'({$urandom(), $urandom()});
         end
         issue_valid = ($urandom_range(0, 3) == 0);
         issue_rd = AW'($urandom());
         q_rs1 = AW'($urandom());
         q_rs2 = AW'($urandom());
         cycle();
      end

      // Asynchronous reset mid-operation drops everything at once.
      alu_valid = 1'b1; alu_rd = 5'd2; mem_valid = 1'b1; mem_rd = 5'd6;
      cycle();
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_reg_write", 64'(reg_write), 64'(0));
      chk("midreset_fifo_count", 64'(fifo_count), 64'(0));
      chk("midreset_mem_ready", 64'(mem_ready), 64'(0));
      q_rs1 = 5'd9;
      #1;
      chk("midreset_busy", 64'(rs1_busy), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      chk("midreset_no_write", 64'(reg_write), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that sits directly upstream of the 32×48-bit register file and drives its rd_addr/rd_data/reg_write write port. It merges single-cycle ALU results with long-latency (load/multiply) results buffered in a small FIFO, and grants the ALU priority with a starvation guard. It also keeps a per-register busy scoreboard so the issue stage can stall on operands whose long-latency result has not yet reached the register file.

## Interface
- DATA_W, 48, result/register data width
- ADDR_W, 5, register address width (32 registers, r0 hardwired zero)
- FIFO_DEPTH, 4, long-latency result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may be passed over before the ALU is held off

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready; registered
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  long-latency result present
- mem_ready  out  1  FIFO can accept; push on mem_valid && mem_ready
- mem_rd  in  ADDR_W  long-latency destination register
- mem_data  in  DATA_W  long-latency result
- issue_valid  in  1  a long-latency op is issued this cycle
- issue_rd  in  ADDR_W  its destination; marks register busy
- q_rs1, q_rs2  in  ADDR_W  scoreboard query addresses
- rs1_busy, rs2_busy  out  1  combinational busy bit of queried register (always 0 for r0)
- rd_addr  out  ADDR_W  register file write address; registered
- rd_data  out  DATA_W  register file write data; registered
- reg_write  out  1  register file write enable; registered
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: circular buffer, wrapping read/write pointers, separate count. mem_ready = (count < FIFO_DEPTH); forced 0 while reset_n low. No bypass: a pushed entry is poppable from the next cycle onward.
- Selection each cycle (one write per cycle):
  - alu_valid && alu_ready → ALU result loaded into output registers; FIFO not popped.
  - otherwise, if FIFO non-empty → head popped into output registers, wb_from_mem flag set.
  - otherwise → reg_write loads 0.
- reg_write loads (selected rd != 0); a result destined for r0 still consumes its slot/pop but produces no write.
- Starvation: starve_cnt increments each cycle the FIFO is non-empty and not popped; clears on every pop and whenever the FIFO is empty. When starve_cnt reaches STARVE_LIMIT−1 at an edge, alu_ready is driven 0 for exactly the next cycle, and in that cycle the FIFO head is popped regardless of alu_valid. Upstream holds its ALU result while alu_ready is 0.
- Scoreboard busy[31:0]:
  - set at the edge where issue_valid && issue_rd != 0.
  - clear at the edge where reg_write && wb_from_mem for rd_addr, i.e. the same edge at which the register file captures the data, so a reader never sees busy=0 with stale data.
  - set and clear of the same register on the same edge: set wins.
  - ALU writes never alter busy (WAW ordering is the issue stage's responsibility).
- Push while count == FIFO_DEPTH cannot occur (mem_ready low); mem_valid with mem_ready low is ignored, and the source holds.

## Timing
- Reset (reset_n low, asynchronous): reg_write=0, rd_addr=0, rd_data=0, alu_ready=1, fifo_count=0, mem_ready=0, busy all 0, starve_cnt=0, pointers 0, wb_from_mem=0.
- ALU latency: result accepted at edge T → reg_write high during cycle T..T+1 → register file written at edge T+1.
- Long-latency minimum: pushed at edge T, popped at edge T+1, register file written at T+2, busy cleared at T+2.
- Worst-case FIFO head wait with continuous alu_valid: STARVE_LIMIT cycles.
- Reset mid-operation drops all FIFO contents and in-flight writes; nothing is written after reset_n falls.

## Test plan
- Reset: hold reset_n low with mem_valid=1 → mem_ready=0, reg_write=0, fifo_count=0; release → mem_ready=1, alu_ready=1.
- ALU only: alu_valid, rd=7, data=0x0000_1234_5678 at edge T → rd_addr=7, rd_data=0x000012345678, reg_write=1 in the following cycle; rd=0 gives reg_write=0.
- Scoreboard: issue rd=9, then push mem result rd=9 with alu idle → rs1_busy(q=9)=1 until the register-file write edge; busy and reg_write commit on the same edge. Issue and clear of rd=9 on the same edge → busy stays 1.
- FIFO full: push 4 mem results with continuous alu_valid → fifo_count=4, mem_ready=0; a 5th mem_valid is held, not lost; results retire in order.
- Starvation: FIFO non-empty plus alu_valid every cycle → after 4 cycles alu_ready=0 for one cycle, FIFO head written, ALU result written the following cycle unchanged.
